// File: rtl/d_ff.sv
// Positive-edge D flip-flop with asynchronous active-low reset and parameterised width.
// Basic storage element of the register file; any enable/hold mux lives outside.
module d_ff #(
  parameter int unsigned           WIDTH       = 1,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  always_comb begin
    q_d = d;
  end

  // Reset wins over a coincident clock edge because it is checked first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: tb/tb_d_ff.sv
// Self-checking bench for d_ff: vector table plus hand-written multi-cycle sequences,
// with expected values queued at stimulus time and popped when the output is sampled.
module tb_d_ff;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        d = 1'b0;
  logic        q;
  logic        en = 1'b0;
  logic        din = 1'b0;
  logic        d_fb;
  logic        q_fb;
  logic [63:0] d64 = '0;
  logic [63:0] q64;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic rst;
    logic d;
    logic exp;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  d_ff dut (
    .clk  (clk),
    .reset(reset),
    .d    (d),
    .q    (q)
  );

  assign d_fb = en ? din : q_fb;

  d_ff dut_fb (
    .clk  (clk),
    .reset(reset),
    .d    (d_fb),
    .q    (q_fb)
  );

  d_ff #(
    .WIDTH      (64),
    .RESET_VALUE(64'hA5)
  ) dut64 (
    .clk  (clk),
    .reset(reset),
    .d    (d64),
    .q    (q64)
  );

  task automatic expect_val(input logic [63:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act);
    logic [63:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: got %h but no expected value was queued", name, act);
      return;
    end
    e = exp_q.pop_front();
    if (act !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, e);
    end
  endtask

  task automatic after_pos();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{rst: 1'b0, d: 1'b1, exp: 1'b0};
    vecs[1] = '{rst: 1'b0, d: 1'b1, exp: 1'b0};
    vecs[2] = '{rst: 1'b1, d: 1'b1, exp: 1'b1};
    vecs[3] = '{rst: 1'b1, d: 1'b0, exp: 1'b0};
    vecs[4] = '{rst: 1'b1, d: 1'b1, exp: 1'b1};
    vecs[5] = '{rst: 1'b1, d: 1'b1, exp: 1'b1};
    vecs[6] = '{rst: 1'b1, d: 1'b0, exp: 1'b0};
    vecs[7] = '{rst: 1'b0, d: 1'b1, exp: 1'b0};
    vecs[8] = '{rst: 1'b1, d: 1'b0, exp: 1'b0};
    vecs[9] = '{rst: 1'b1, d: 1'b1, exp: 1'b1};

    // Power-up reset before the first clock edge.
    #2;
    reset = 1'b0;
    #1;
    expect_val(64'd0);  check("por_q", q);
    expect_val(64'd0);  check("por_q_fb", q_fb);
    expect_val(64'hA5); check("por_q64", q64);

    // Capture after release, then asynchronous clear mid-cycle.
    @(negedge clk);
    reset = 1'b1;
    d = 1'b1;
    expect_val(64'd1);
    after_pos();
    check("capture_one", q);
    #2;
    reset = 1'b0;
    #1;
    expect_val(64'd0);
    check("async_clear_immediate", q);
    expect_val(64'd0);
    after_pos();
    check("held_in_reset", q);

    // Vector table: drive on falling edge, sample just after rising edge.
    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst;
      d = vecs[i].d;
      expect_val({63'd0, vecs[i].exp});
      after_pos();
      check($sformatf("vec%0d", i), q);
    end

    // Hold between edges: d glitches and falling edges must not disturb q.
    @(negedge clk);
    reset = 1'b1;
    d = 1'b0;
    expect_val(64'd0);
    after_pos();
    check("hold_base0", q);
    d = 1'b1; #1; d = 1'b0; #1; d = 1'b1;
    @(negedge clk);
    #1;
    expect_val(64'd0);
    check("hold_after_negedge0", q);
    expect_val(64'd1);
    after_pos();
    check("hold_capture1", q);
    d = 1'b0; #1; d = 1'b1; #1; d = 1'b0;
    @(negedge clk);
    #1;
    expect_val(64'd1);
    check("hold_after_negedge1", q);
    d = 1'b1;

    // Reset asserted at a rising edge, released just after another rising edge.
    @(posedge clk);
    reset = 1'b0;
    #1;
    expect_val(64'd0);
    check("reset_at_edge", q);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    expect_val(64'd0);
    check("no_capture_on_release_edge", q);
    expect_val(64'd1);
    after_pos();
    check("first_capture_after_release", q);

    // Register-style hold through external feedback mux.
    @(negedge clk);
    reset = 1'b0;
    en = 1'b0;
    din = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      expect_val(64'd0);
      after_pos();
      check($sformatf("fb_hold0_%0d", i), q_fb);
    end
    @(negedge clk);
    en = 1'b1;
    expect_val(64'd1);
    after_pos();
    check("fb_load", q_fb);
    @(negedge clk);
    en = 1'b0;
    din = 1'b0;
    for (int i = 0; i < 5; i++) begin
      expect_val(64'd1);
      after_pos();
      check($sformatf("fb_hold1_%0d", i), q_fb);
    end
    #2;
    reset = 1'b0;
    #1;
    expect_val(64'd0);
    check("fb_reset", q_fb);

    // Wide instance with non-zero reset value.
    expect_val(64'hA5);
    check("w64_reset", q64);
    @(negedge clk);
    reset = 1'b1;
    d64 = 64'h1;
    expect_val(64'h1);
    after_pos();
    check("w64_one", q64);
    @(negedge clk);
    d64 = 64'hFFFF_FFFF_FFFF_FFFF;
    expect_val(64'hFFFF_FFFF_FFFF_FFFF);
    after_pos();
    check("w64_ones", q64);
    @(negedge clk);
    d64 = 64'h0123_4567_89AB_CDEF;
    expect_val(64'h0123_4567_89AB_CDEF);
    after_pos();
    check("w64_pattern", q64);
    #2;
    reset = 1'b0;
    #1;
    expect_val(64'hA5);
    check("w64_async_reset", q64);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
